mem_access_unit: RTL and testbench

//  Initiator side of the data-memory bus: converts CPU load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW)

---
 rtl/mau_pkg.sv | 56 +++++
 rtl/mem_access_unit_if.sv | 31 +++
 rtl/mau_lane_align.sv | 54 +++++
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// ----------------------------------------------------------------------------
// mau_pkg
// Shared types and constants for the data-memory access unit.
//   op_e        : CPU load/store operation encoding
//   state_e     : access FSM states
//   DMEM_WORDS  : data memory depth in 32-bit words
//   DMEM_ADDR_W : word-address width derived from DMEM_WORDS
//   DMEM_BASE   : byte address that maps to DMEM word 0
//   helpers     : is_store, is_subword_store, is_misaligned
// ----------------------------------------------------------------------------
package mau_pkg;

    localparam int          DMEM_WORDS  = 2048;
    localparam int          DMEM_ADDR_W = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_BASE   = 32'h1001_0000;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WR   = 3'd2,
        ST_RESP = 3'd3,
        ST_ERR  = 3'd4
    } state_e;

    function automatic logic is_store(op_e op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_subword_store(op_e op);
        return (op == OP_SB) || (op == OP_SH);
    endfunction

    // Halfword accesses need an even address, word accesses a multiple of 4.
    function automatic logic is_misaligned(op_e op, logic [1:0] lane);
        logic bad;
        bad = 1'b0;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = lane[0];
            OP_LW, OP_SW:         bad = |lane;
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// ----------------------------------------------------------------------------
// mem_access_unit_if
// DMEM bus between the access unit (master) and the data memory (slave).
//   cs, r, w : chip-select / read strobe / write strobe
//   sb, sh   : byte / halfword write qualifiers (native sub-word writes)
//   addr     : DMEM word index
//   wdata    : write data
//   rdata    : combinational read data from DMEM
// ----------------------------------------------------------------------------
interface mem_access_unit_if #(
    parameter int ADDR_W = mau_pkg::DMEM_ADDR_W
);
    logic              cs;
    logic              r;
    logic              w;
    logic              sb;
    logic              sh;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;

    modport master (
        output cs, r, w, sb, sh, addr, wdata,
        input  rdata
    );

    modport slave (
        input  cs, r, w, sb, sh, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/mau_lane_align.sv
// ----------------------------------------------------------------------------
// mau_lane_align
// Combinational byte-lane steering for the access unit (little-endian,
// lane 0 = bits [7:0]).
//   op         : operation of the captured request
//   lane       : byte offset within the word (addr[1:0])
//   word       : word read from DMEM
//   store_data : right-justified store data (low halfword is enough)
//   load_data  : selected byte/half/word, sign- or zero-extended; 0 for stores
//   merged     : word with the SB/SH data inserted into the selected lane,
//                all other lanes unchanged
// ----------------------------------------------------------------------------
module mau_lane_align
    import mau_pkg::*;
(
    input  op_e         op,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [15:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of this block gets a default before the case
    // statements, so no path leaves a value unassigned and no latch appears.
    always_comb begin
        byte_sel  = word[{lane, 3'b000} +: 8];
        half_sel  = lane[1] ? word[31:16] : word[15:0];

        load_data = '0;
        case (op)
            OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data = {24'h0, byte_sel};
            OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_data = {16'h0, half_sel};
            OP_LW:   load_data = word;
            default: load_data = '0;
        endcase

        merged = word;
        case (op)
            OP_SB: merged[{lane, 3'b000} +: 8] = store_data[7:0];
            OP_SH: begin
                if (lane[1]) merged[31:16] = store_data;
                else         merged[15:0]  = store_data;
            end
            default: merged = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
// Initiator side of the data-memory bus. Turns CPU load/store requests into
// DMEM cycles, aligns byte lanes, extends loads, performs read-modify-write
// for sub-word stores and flags misaligned accesses.
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : request handshake (ready only in IDLE)
//   req_op/addr/wdata : operation, byte address, right-justified store data
//   resp_valid        : one-cycle completion pulse (no backpressure)
//   resp_rdata        : extended load data, 0 for stores and errors
//   resp_err          : misaligned access, qualified by resp_valid
//   mem               : DMEM bus (master modport)
// Build option: define MAU_NATIVE_SUBWORD_EN to send lane-0 SB/SH as a single
// qualified write instead of read-modify-write.
// ----------------------------------------------------------------------------
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int          ADDR_W    = DMEM_ADDR_W,
    parameter logic [31:0] BASE_ADDR = DMEM_BASE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  op_e                req_op,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               resp_valid,
    output logic [31:0]        resp_rdata,
    output logic               resp_err,
    mem_access_unit_if.master  mem
);

`ifdef MAU_NATIVE_SUBWORD_EN
    localparam bit NATIVE_EN = 1'b1;
`else
    localparam bit NATIVE_EN = 1'b0;
`endif

    state_e            state_q, state_d;
    op_e               op_q;
    logic [1:0]        lane_q;
    logic [ADDR_W-1:0] widx_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;

    logic [31:0]       byte_off;
    logic              accept;
    logic              native_req;
    logic              native_wr;
    logic [31:0]       load_data;
    logic [31:0]       merged;
    logic              unused_off_hi;

    // Offset into the DMEM window; out-of-window addresses simply wrap onto
    // the low ADDR_W bits of the word index.
    assign byte_off      = req_addr - BASE_ADDR;
    assign unused_off_hi = ^byte_off[31:ADDR_W+2];
    assign accept        = req_valid && (state_q == ST_IDLE);

    // Lane-0 sub-word stores can skip the read when the memory accepts
    // byte/halfword write qualifiers.
    assign native_req = NATIVE_EN && is_subword_store(req_op) && (byte_off[1:0] == 2'b00);
    assign native_wr  = NATIVE_EN && is_subword_store(op_q)   && (lane_q == 2'b00);

    mau_lane_align u_lane_align (
        .op         (op_q),
        .lane       (lane_q),
        .word       (rdata_q),
        .store_data (wdata_q[15:0]),
        .load_data  (load_data),
        .merged     (merged)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the captured request fields are reset too, so mem_addr and the
    // response data come up as zero instead of X after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_LB;
            lane_q  <= 2'b00;
            widx_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= req_op;
                lane_q  <= byte_off[1:0];
                widx_q  <= byte_off[ADDR_W+1:2];
                wdata_q <= req_wdata;
            end
            // RD is the only state where DMEM drives valid read data.
            if (state_q == ST_RD) begin
                rdata_q <= mem.rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_misaligned(req_op, byte_off[1:0])) state_d = ST_ERR;
                    else if (!is_store(req_op))                state_d = ST_RD;
                    else if (is_subword_store(req_op) && !native_req) state_d = ST_RD;
                    else                                       state_d = ST_WR;
                end
            end
            ST_RD:   state_d = is_store(op_q) ? ST_WR : ST_RESP;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so an asynchronous
    // reset drops the bus strobes in the same cycle.
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = '0;
        mem.cs     = 1'b0;
        mem.r      = 1'b0;
        mem.w      = 1'b0;
        mem.sb     = 1'b0;
        mem.sh     = 1'b0;
        mem.wdata  = '0;
        case (state_q)
            ST_RD: begin
                mem.cs = 1'b1;
                mem.r  = 1'b1;
            end
            ST_WR: begin
                mem.cs = 1'b1;
                mem.w  = 1'b1;
                mem.sb = native_wr && (op_q == OP_SB);
                mem.sh = native_wr && (op_q == OP_SH);
                if ((op_q == OP_SW) || native_wr) mem.wdata = wdata_q;
                else                              mem.wdata = merged;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = is_store(op_q) ? 32'h0 : load_data;
            end
            ST_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem.addr = widx_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
// Directed bench for mem_access_unit. Requests push their hand-computed
// response and DMEM bus cycles into queues; independent monitors pop and
// compare whenever the DUT shows a response or a bus cycle.
// Honors MAU_NATIVE_SUBWORD_EN for the lane-0 sub-word store vectors.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;
    import mau_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    op_e         req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    mem_access_unit_if #(.ADDR_W(DMEM_ADDR_W)) mem_bus ();

    mem_access_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem        (mem_bus)
    );

    // DMEM model: combinational read, posedge write.
    logic [31:0] dmem [DMEM_WORDS];

    assign mem_bus.rdata = mem_bus.r ? dmem[mem_bus.addr] : 32'bz;

    always @(posedge clk) begin
        if (mem_bus.cs && mem_bus.w) begin
            if (mem_bus.sb)      dmem[mem_bus.addr][7:0]  <= mem_bus.wdata[7:0];
            else if (mem_bus.sh) dmem[mem_bus.addr][15:0] <= mem_bus.wdata[15:0];
            else                 dmem[mem_bus.addr]       <= mem_bus.wdata;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [3:0]             kind;   // {r, w, sb, sh}
        logic [DMEM_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        int                     cyc;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    // Response monitor.
    always @(negedge clk) begin
        resp_t e;
        if (rst_n && resp_valid) begin
            if (resp_q.size() == 0) begin
                check("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = resp_q.pop_front();
                check("resp_rdata", resp_rdata, e.rdata);
                check("resp_err",   {31'h0, resp_err}, {31'h0, e.err});
                check("resp_cycle", cyc, e.cyc);
            end
        end
    end

    // Bus monitor: every cycle with chip-select must match the next expected bus cycle.
    always @(negedge clk) begin
        bus_t e;
        if (mem_bus.cs) begin
            if (bus_q.size() == 0) begin
                check("bus_unexpected", 32'd1, 32'd0);
            end else begin
                e = bus_q.pop_front();
                check("bus_kind",  {28'h0, mem_bus.r, mem_bus.w, mem_bus.sb, mem_bus.sh}, {28'h0, e.kind});
                check("bus_addr",  {21'h0, mem_bus.addr}, {21'h0, e.addr});
                check("bus_wdata", mem_bus.wdata, e.wdata);
                check("bus_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check("req_ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request. rd/wr say which bus cycles are expected; sub={sb,sh}
    // qualifiers on the write; resp arrives 1+rd+wr cycles after issue.
    task automatic run(input op_e op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err,
                       input logic rd, input logic wr, input logic [1:0] sub,
                       input logic [DMEM_ADDR_W-1:0] widx, input logic [31:0] exp_wdata);
        int c;
        wait_ready();
        c = cyc;
        if (rd) bus_q.push_back('{kind: 4'b1000, addr: widx, wdata: 32'h0, cyc: c + 1});
        if (wr) bus_q.push_back('{kind: {2'b01, sub}, addr: widx, wdata: exp_wdata, cyc: c + 1 + int'(rd)});
        resp_q.push_back('{rdata: exp_rdata, err: exp_err, cyc: c + 1 + int'(rd) + int'(wr)});
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = OP_LB;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = 32'h0;
        dmem[0]  = 32'h80FF_7F01;
        dmem[1]  = 32'h1122_3344;
        dmem[2]  = 32'hDEAD_BEEF;
        dmem[10] = 32'h0F0F_0F0F;

        repeat (3) @(negedge clk);
        check("rst_req_ready",  {31'h0, req_ready},  32'd1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'h0, resp_err},   32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_bus_ctrl",   {27'h0, mem_bus.cs, mem_bus.r, mem_bus.w, mem_bus.sb, mem_bus.sh}, 32'h0);
        check("rst_bus_addr",   {21'h0, mem_bus.addr}, 32'h0);
        check("rst_bus_wdata",  mem_bus.wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Word load.
        run(OP_LW,  32'h1001_0008, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 2'b00, 11'd2, 32'h0);
        // Byte/half loads from word 0 = 0x80FF7F01.
        run(OP_LB,  32'h1001_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_LBU, 32'h1001_0003, 32'h0, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_LH,  32'h1001_0002, 32'h0, 32'hFFFF_80FF, 1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_LHU, 32'h1001_0000, 32'h0, 32'h0000_7F01, 1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_LB,  32'h1001_0001, 32'h0, 32'h0000_007F, 1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_LBU, 32'h1001_0002, 32'h0, 32'h0000_00FF, 1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 32'h0);

        // Sub-word RMW on word 1 = 0x11223344; upper store bits must be ignored.
        run(OP_SB,  32'h1001_0005, 32'hFFFF_FFAB, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 11'd1, 32'h1122_AB44);
        run(OP_LW,  32'h1001_0004, 32'h0, 32'h1122_AB44, 1'b0, 1'b1, 1'b0, 2'b00, 11'd1, 32'h0);
        run(OP_SH,  32'h1001_0006, 32'h1234_CAFE, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 11'd1, 32'hCAFE_AB44);
        run(OP_SB,  32'h1001_0007, 32'h0000_005A, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 11'd1, 32'h5AFE_AB44);
        run(OP_LW,  32'h1001_0004, 32'h0, 32'h5AFE_AB44, 1'b0, 1'b1, 1'b0, 2'b00, 11'd1, 32'h0);

        // Misaligned accesses: error after one cycle, no bus activity.
        run(OP_LW,  32'h1001_0002, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_SH,  32'h1001_0001, 32'h0000_9999, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_LHU, 32'h1001_0003, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_SW,  32'h1001_0005, 32'h1111_1111, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_LW,  32'h1001_0000, 32'h0, 32'h80FF_7F01, 1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 32'h0);

        // Full-word store, read back through an address that wraps the window.
        run(OP_SW,  32'h1001_000C, 32'h0123_4567, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 11'd3, 32'h0123_4567);
        run(OP_LW,  32'h1001_200C, 32'h0, 32'h0123_4567, 1'b0, 1'b1, 1'b0, 2'b00, 11'd3, 32'h0);

        // Lane-0 sub-word stores.
`ifdef MAU_NATIVE_SUBWORD_EN
        run(OP_SH,  32'h1001_0000, 32'h0000_BEEF, 32'h0, 1'b0, 1'b0, 1'b1, 2'b01, 11'd0, 32'h0000_BEEF);
        run(OP_SB,  32'h1001_0008, 32'h0000_0077, 32'h0, 1'b0, 1'b0, 1'b1, 2'b10, 11'd2, 32'h0000_0077);
`else
        run(OP_SH,  32'h1001_0000, 32'h0000_BEEF, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 11'd0, 32'h80FF_BEEF);
        run(OP_SB,  32'h1001_0008, 32'h0000_0077, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 11'd2, 32'hDEAD_BE77);
`endif
        run(OP_LW,  32'h1001_0000, 32'h0, 32'h80FF_BEEF, 1'b0, 1'b1, 1'b0, 2'b00, 11'd0, 32'h0);
        run(OP_LW,  32'h1001_0008, 32'h0, 32'hDEAD_BE77, 1'b0, 1'b1, 1'b0, 2'b00, 11'd2, 32'h0);

        // Reset in the middle of a SW write cycle: no write, no response.
        wait_ready();
        c = cyc;
        bus_q.push_back('{kind: 4'b0100, addr: 11'd10, wdata: 32'h5555_AAAA, cyc: c + 1});
        req_op    = OP_SW;
        req_addr  = 32'h1001_0028;
        req_wdata = 32'h5555_AAAA;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstwr_w_before", {31'h0, mem_bus.w}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstwr_bus_drop", {30'h0, mem_bus.cs, mem_bus.w}, 32'd0);
        check("rstwr_ready",    {31'h0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check("rstwr_no_write", dmem[10], 32'h0F0F_0F0F);
        @(negedge clk);
        check("rstwr_ready_after", {31'h0, req_ready}, 32'd1);
        run(OP_LW,  32'h1001_0028, 32'h0, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0, 2'b00, 11'd10, 32'h0);

        // Drain outstanding expectations.
        n = 0;
        while ((resp_q.size() != 0 || bus_q.size() != 0) && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("resp_queue_empty", resp_q.size(), 32'd0);
        check("bus_queue_empty",  bus_q.size(),  32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
